matrix_op_scalar_alu: RTL and testbench

Parametrised element-wise matrix/scalar ALU for the matrix operation layer. It reads a source matrix from matrix storage through the shared single read port, and takes its scalar either from a 1x1 matrix or from an immediate. It applies MUL, ADD or SUB in signed fixed-point with optional saturation, and streams the result through the matrix writer handshake into a caller-selected destination slot.

---
 rtl/matrix_op_scalar_alu_if.sv | 48 ++++
 rtl/matrix_op_scalar_alu.sv | 230 +++++++++++++++++++++++
 tb/tb_matrix_op_scalar_alu.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_op_scalar_alu_if.sv
// rtl/matrix_op_scalar_alu_if.sv - storage read port and matrix writer handshake
interface matrix_op_scalar_alu_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] read_addr;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  write_ready;
    logic                  write_request;
    logic [2:0]            matrix_id;
    logic [7:0]            actual_rows;
    logic [7:0]            actual_cols;
    logic [7:0][7:0]       matrix_name;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  data_valid;
    logic                  writer_ready;
    logic                  write_done;

    modport master (
        output read_addr,
        input  data_out,
        input  write_ready,
        output write_request,
        output matrix_id,
        output actual_rows,
        output actual_cols,
        output matrix_name,
        output data_in,
        output data_valid,
        input  writer_ready,
        input  write_done
    );

    modport slave (
        input  read_addr,
        output data_out,
        output write_ready,
        input  write_request,
        input  matrix_id,
        input  actual_rows,
        input  actual_cols,
        input  matrix_name,
        input  data_in,
        input  data_valid,
        output writer_ready,
        output write_done
    );
endinterface

// File: rtl/matrix_op_scalar_alu.sv
// rtl/matrix_op_scalar_alu.sv - element-wise matrix/scalar MUL/ADD/SUB with saturation
package matrix_op_scalar_alu_pkg;
    typedef enum logic [3:0] {
        STATUS_IDLE         = 4'd0,
        STATUS_BUSY         = 4'd1,
        STATUS_SUCCESS      = 4'd2,
        STATUS_ERR_ID       = 4'd3,
        STATUS_ERR_FORMAT   = 4'd4,
        STATUS_ERR_EMPTY    = 4'd5,
        STATUS_ERR_DIM      = 4'd6,
        STATUS_ERR_INTERNAL = 4'd7
    } matrix_op_status_e;

    // Shape word sits at slot base; elements follow row-major.
    localparam int MATRIX_METADATA_WORDS = 1;
endpackage

module matrix_op_scalar_alu
    import matrix_op_scalar_alu_pkg::*;
#(
    parameter int MATRIX_BLOCK_SIZE = 128,
    parameter int BLOCK_SIZE        = MATRIX_BLOCK_SIZE,
    parameter int MATRIX_ADDR_WIDTH = 10,
    parameter int ADDR_WIDTH        = MATRIX_ADDR_WIDTH,
    parameter int MATRIX_DATA_WIDTH = 32,
    parameter int DATA_WIDTH        = MATRIX_DATA_WIDTH,
    parameter int FRAC_BITS         = 0,
    parameter bit SATURATE          = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [1:0]            op_mode,
    input  logic [2:0]            matrix_src_id,
    input  logic [2:0]            matrix_scalar_id,
    input  logic [2:0]            matrix_dst_id,
    input  logic                  use_imm,
    input  logic [DATA_WIDTH-1:0] imm_value,
    output logic                  busy,
    output matrix_op_status_e     status,
    matrix_op_scalar_alu_if.master bus
);
    localparam int DW = DATA_WIDTH;

    typedef enum logic [4:0] {
        IDLE, CHECK_IDS, SRC_META_ADDR, SRC_META_WAIT, SCLR_META_ADDR, SCLR_META_WAIT,
        VALIDATE, SCLR_DATA_ADDR, SCLR_DATA_WAIT, WAIT_WRITE_READY, ASSERT_WRITE_REQ,
        WAIT_WRITER_ENABLE, PREPARE_ADDR, WAIT_DATA, WRITE_DATA, CHECK_NEXT,
        WAIT_WRITE_DONE, DONE
    } state_e;

    state_e                state_q, state_d;
    matrix_op_status_e     status_q, val_code;
    logic [1:0]            op_q;
    logic [2:0]            src_q, sc_q, dst_q;
    logic                  use_imm_q, id_err;
    logic [DW-1:0]         scalar_q, data_in_q, alu_result;
    logic [7:0]            rows_q, cols_q, sc_rows_q, sc_cols_q;
    logic [15:0]           count_q, sc_count_q, idx_q;
    logic [ADDR_WIDTH-1:0] addr_q;

    logic signed [DW-1:0]   a_s, b_s;
    logic signed [2*DW-1:0] prod, wide;
    logic signed [DW:0]     sum;
    logic [DW:0]            top;
    logic                   ovf;

    // A slot is usable only if it lies entirely inside the address space.
    function automatic logic is_valid_operand_id(input logic [2:0] id);
        return ((int'(id) + 1) * BLOCK_SIZE) <= (1 << ADDR_WIDTH);
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] slot_base(input logic [2:0] id);
        return ADDR_WIDTH'(int'(id) * BLOCK_SIZE);
    endfunction

    function automatic logic fits(input logic [15:0] n);
        return (32'(n) + 32'(MATRIX_METADATA_WORDS)) <= 32'(BLOCK_SIZE);
    endfunction

    assign id_err = !is_valid_operand_id(src_q)
                  || (!use_imm_q && !is_valid_operand_id(sc_q))
                  || (dst_q == src_q)
                  || (!use_imm_q && (dst_q == sc_q));

    assign busy              = (state_q != IDLE);
    assign status            = status_q;
    assign bus.read_addr     = addr_q;
    assign bus.write_request = (state_q == ASSERT_WRITE_REQ);
    assign bus.data_valid    = (state_q == WRITE_DATA);
    assign bus.data_in       = data_in_q;
    assign bus.matrix_id     = dst_q;
    assign bus.actual_rows   = rows_q;
    assign bus.actual_cols   = cols_q;
    assign bus.matrix_name   = 64'h0000_0055_4C41_4353;

    // Shape checks in priority order; STATUS_BUSY means "no error".
    always_comb begin
        val_code = STATUS_BUSY;
        if (rows_q == 8'd0 || cols_q == 8'd0 || count_q == 16'd0)
            val_code = STATUS_ERR_EMPTY;
        else if (!fits(count_q) || (!use_imm_q && !fits(sc_count_q)))
            val_code = STATUS_ERR_FORMAT;
        else if (!use_imm_q && (sc_rows_q != 8'd1 || sc_cols_q != 8'd1))
            val_code = STATUS_ERR_DIM;
    end

    // Fixed-point arithmetic on the element currently on data_out.
    always_comb begin
        a_s  = bus.data_out;
        b_s  = scalar_q;
        prod = (2*DW)'(a_s) * (2*DW)'(b_s);
        if (op_q == 2'd2)
            sum = {a_s[DW-1], a_s} - {b_s[DW-1], b_s};
        else
            sum = {a_s[DW-1], a_s} + {b_s[DW-1], b_s};
        if (op_q == 2'd0)
            wide = prod >>> FRAC_BITS;
        else
            wide = {{(DW-1){sum[DW]}}, sum};
        top = wide[2*DW-1:DW-1];
        ovf = !((&top) || !(|top));
        if (SATURATE && ovf)
            alu_result = wide[2*DW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        else
            alu_result = wide[DW-1:0];
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:               if (start) state_d = CHECK_IDS;
            CHECK_IDS:          state_d = (id_err || op_q == 2'd3) ? DONE : SRC_META_ADDR;
            SRC_META_ADDR:      state_d = SRC_META_WAIT;
            SRC_META_WAIT:      state_d = use_imm_q ? VALIDATE : SCLR_META_ADDR;
            SCLR_META_ADDR:     state_d = SCLR_META_WAIT;
            SCLR_META_WAIT:     state_d = VALIDATE;
            VALIDATE: begin
                if (val_code != STATUS_BUSY) state_d = DONE;
                else state_d = use_imm_q ? WAIT_WRITE_READY : SCLR_DATA_ADDR;
            end
            SCLR_DATA_ADDR:     state_d = SCLR_DATA_WAIT;
            SCLR_DATA_WAIT:     state_d = WAIT_WRITE_READY;
            WAIT_WRITE_READY:   if (bus.write_ready) state_d = ASSERT_WRITE_REQ;
            ASSERT_WRITE_REQ:   state_d = WAIT_WRITER_ENABLE;
            WAIT_WRITER_ENABLE: if (bus.writer_ready) state_d = PREPARE_ADDR;
            PREPARE_ADDR:       state_d = WAIT_DATA;
            WAIT_DATA:          state_d = WRITE_DATA;
            WRITE_DATA:         if (bus.writer_ready) state_d = CHECK_NEXT;
            CHECK_NEXT:         state_d = (idx_q >= count_q) ? WAIT_WRITE_DONE : PREPARE_ADDR;
            WAIT_WRITE_DONE:    if (bus.write_done) state_d = DONE;
            DONE:               state_d = IDLE;
            default:            state_d = IDLE;
        endcase
    end

    // Operand latching, metadata capture, addressing, result register and status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q       <= 2'd0;
            src_q      <= 3'd0;
            sc_q       <= 3'd0;
            dst_q      <= 3'd0;
            use_imm_q  <= 1'b0;
            scalar_q   <= '0;
            rows_q     <= 8'd0;
            cols_q     <= 8'd0;
            count_q    <= 16'd0;
            sc_rows_q  <= 8'd0;
            sc_cols_q  <= 8'd0;
            sc_count_q <= 16'd0;
            idx_q      <= 16'd0;
            addr_q     <= '0;
            data_in_q  <= '0;
            status_q   <= STATUS_IDLE;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    op_q       <= op_mode;
                    src_q      <= matrix_src_id;
                    sc_q       <= matrix_scalar_id;
                    dst_q      <= matrix_dst_id;
                    use_imm_q  <= use_imm;
                    scalar_q   <= imm_value;
                    rows_q     <= 8'd0;
                    cols_q     <= 8'd0;
                    count_q    <= 16'd0;
                    sc_rows_q  <= 8'd0;
                    sc_cols_q  <= 8'd0;
                    sc_count_q <= 16'd0;
                    idx_q      <= 16'd0;
                    status_q   <= STATUS_BUSY;
                end
                CHECK_IDS: begin
                    if (id_err) status_q <= STATUS_ERR_ID;
                    else if (op_q == 2'd3) status_q <= STATUS_ERR_FORMAT;
                end
                SRC_META_ADDR: addr_q <= slot_base(src_q);
                SRC_META_WAIT: begin
                    rows_q  <= bus.data_out[15:8];
                    cols_q  <= bus.data_out[7:0];
                    count_q <= 16'(bus.data_out[15:8]) * 16'(bus.data_out[7:0]);
                end
                SCLR_META_ADDR: addr_q <= slot_base(sc_q);
                SCLR_META_WAIT: begin
                    sc_rows_q  <= bus.data_out[15:8];
                    sc_cols_q  <= bus.data_out[7:0];
                    sc_count_q <= 16'(bus.data_out[15:8]) * 16'(bus.data_out[7:0]);
                end
                VALIDATE: if (val_code != STATUS_BUSY) status_q <= val_code;
                SCLR_DATA_ADDR: addr_q <= slot_base(sc_q) + ADDR_WIDTH'(MATRIX_METADATA_WORDS);
                SCLR_DATA_WAIT: scalar_q <= bus.data_out;
                PREPARE_ADDR: addr_q <= slot_base(src_q) + ADDR_WIDTH'(MATRIX_METADATA_WORDS)
                                        + ADDR_WIDTH'(idx_q);
                WAIT_DATA: data_in_q <= alu_result;
                WRITE_DATA: if (bus.writer_ready) idx_q <= idx_q + 16'd1;
                WAIT_WRITE_DONE: if (bus.write_done) status_q <= STATUS_SUCCESS;
                WAIT_WRITE_READY, ASSERT_WRITE_REQ, WAIT_WRITER_ENABLE, CHECK_NEXT, DONE: ;
                default: status_q <= STATUS_ERR_INTERNAL;
            endcase
        end
    end
endmodule

// File: tb/tb_matrix_op_scalar_alu.sv
// tb/tb_matrix_op_scalar_alu.sv - directed self-checking bench for matrix_op_scalar_alu
module tb_matrix_op_scalar_alu;
    import matrix_op_scalar_alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, start, use_imm;
    logic [1:0]  op_mode;
    logic [2:0]  src_id, sc_id, dst_id;
    logic [31:0] imm;
    logic        write_ready, writer_ready, write_done;
    logic        busy_a, busy_b, busy_c;
    matrix_op_status_e status_a, status_b, status_c;

    logic [31:0] mem [1024];
    logic [31:0] res_a [8];
    logic [31:0] res_b [8];
    logic [31:0] res_c [8];
    int checks, errors;
    int rq_a, dv_a, sc_hits;
    int rq0, dv0, sc0;

    always #5 clk = ~clk;

    matrix_op_scalar_alu_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) bus_a ();
    matrix_op_scalar_alu_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) bus_b ();
    matrix_op_scalar_alu_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) bus_c ();

    assign bus_a.data_out = mem[bus_a.read_addr];
    assign bus_b.data_out = mem[bus_b.read_addr];
    assign bus_c.data_out = mem[bus_c.read_addr];
    assign bus_a.write_ready = write_ready;
    assign bus_b.write_ready = write_ready;
    assign bus_c.write_ready = write_ready;
    assign bus_a.writer_ready = writer_ready;
    assign bus_b.writer_ready = writer_ready;
    assign bus_c.writer_ready = writer_ready;
    assign bus_a.write_done = write_done;
    assign bus_b.write_done = write_done;
    assign bus_c.write_done = write_done;

    matrix_op_scalar_alu #(.FRAC_BITS(0), .SATURATE(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .op_mode(op_mode),
        .matrix_src_id(src_id), .matrix_scalar_id(sc_id), .matrix_dst_id(dst_id),
        .use_imm(use_imm), .imm_value(imm), .busy(busy_a), .status(status_a), .bus(bus_a));
    matrix_op_scalar_alu #(.FRAC_BITS(0), .SATURATE(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .op_mode(op_mode),
        .matrix_src_id(src_id), .matrix_scalar_id(sc_id), .matrix_dst_id(dst_id),
        .use_imm(use_imm), .imm_value(imm), .busy(busy_b), .status(status_b), .bus(bus_b));
    matrix_op_scalar_alu #(.FRAC_BITS(8), .SATURATE(1'b1)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(start), .op_mode(op_mode),
        .matrix_src_id(src_id), .matrix_scalar_id(sc_id), .matrix_dst_id(dst_id),
        .use_imm(use_imm), .imm_value(imm), .busy(busy_c), .status(status_c), .bus(bus_c));

    // Event counters on the reference instance; only ever incremented here.
    always @(negedge clk) begin
        if (bus_a.write_request) rq_a++;
        if (bus_a.data_valid) dv_a++;
        if (bus_a.read_addr == 10'd512 || bus_a.read_addr == 10'd513) sc_hits++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [1:0] op, input logic [2:0] s, input logic [2:0] sc,
                            input logic [2:0] d, input logic ui, input logic [31:0] iv);
        @(posedge clk); #1;
        op_mode = op; src_id = s; sc_id = sc; dst_id = d; use_imm = ui; imm = iv;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 60 && busy_a; i++) @(negedge clk);
        chk(tag, busy_a, 1'b0);
    endtask

    task automatic collect(input int n, input int stall_at, input int stall_len);
        int got;
        logic [31:0] held;
        got = 0;
        for (int cyc = 0; cyc < 400 && got < n; cyc++) begin
            @(negedge clk);
            if (bus_a.data_valid) begin
                if (got == stall_at) begin
                    held = bus_a.data_in;
                    writer_ready = 1'b0;
                    for (int k = 0; k < stall_len; k++) begin
                        @(negedge clk);
                        chk("stall_valid", bus_a.data_valid, 1'b1);
                        chk("stall_data", bus_a.data_in, held);
                    end
                    writer_ready = 1'b1;
                end
                res_a[got] = bus_a.data_in;
                res_b[got] = bus_b.data_in;
                res_c[got] = bus_c.data_in;
                got++;
            end
        end
        chk("elem_count", got, n);
        write_done = 1'b1;
        wait_idle("done_timeout");
        write_done = 1'b0;
    endtask

    task automatic run_err(input string tag, input logic [1:0] op, input logic [2:0] s,
                           input logic [2:0] sc, input logic [2:0] d, input logic ui,
                           input matrix_op_status_e exp);
        rq0 = rq_a; dv0 = dv_a;
        do_start(op, s, sc, d, ui, 32'd0);
        wait_idle({tag, "_timeout"});
        chk(tag, status_a, exp);
        chk({tag, "_no_req"}, rq_a - rq0, 0);
        chk({tag, "_no_valid"}, dv_a - dv0, 0);
    endtask

    initial begin
        checks = 0; errors = 0; rq_a = 0; dv_a = 0; sc_hits = 0;
        rst_n = 1'b0; start = 1'b0; op_mode = 2'd0; src_id = 3'd0; sc_id = 3'd0;
        dst_id = 3'd0; use_imm = 1'b0; imm = 32'd0;
        write_ready = 1'b1; writer_ready = 1'b1; write_done = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        mem[0]   = 32'h0203; mem[1] = 32'd1; mem[2] = 32'hFFFFFFFE; mem[3] = 32'd3;
        mem[4]   = 32'd4;    mem[5] = 32'd5; mem[6] = 32'hFFFFFFFA;
        mem[128] = 32'h0101; mem[129] = 32'd3;
        mem[256] = 32'h0101; mem[257] = 32'h7FFFFFFE;
        mem[384] = 32'h0202; mem[385] = 32'd10; mem[386] = 32'd20; mem[387] = 32'd30; mem[388] = 32'd40;
        mem[512] = 32'h0201; mem[513] = 32'd7; mem[514] = 32'd7;
        mem[640] = 32'h0101; mem[641] = 32'h180;
        mem[768] = 32'h0101; mem[769] = 32'h100;
        mem[896] = 32'h0000;

        repeat (3) @(negedge clk);
        chk("rst_busy", busy_a, 1'b0);
        chk("rst_status", status_a, STATUS_IDLE);
        chk("rst_read_addr", bus_a.read_addr, 10'd0);
        chk("rst_write_request", bus_a.write_request, 1'b0);
        chk("rst_data_valid", bus_a.data_valid, 1'b0);
        chk("rst_data_in", bus_a.data_in, 32'd0);
        chk("rst_matrix_id", bus_a.matrix_id, 3'd0);
        chk("rst_rows_cols", {bus_a.actual_rows, bus_a.actual_cols}, 16'd0);
        chk("matrix_name", bus_a.matrix_name, 64'h0000_0055_4C41_4353);
        rst_n = 1'b1;

        // MUL 2x3 by scalar matrix 3; writer initially not ready for a request.
        write_ready = 1'b0;
        rq0 = rq_a;
        do_start(2'd0, 3'd0, 3'd1, 3'd4, 1'b0, 32'd0);
        repeat (20) @(negedge clk);
        chk("mul_held_no_req", rq_a - rq0, 0);
        chk("mul_held_status", status_a, STATUS_BUSY);
        write_ready = 1'b1;
        collect(6, -1, 0);
        chk("mul_e0", res_a[0], 32'd3);
        chk("mul_e1", res_a[1], 32'hFFFFFFFA);
        chk("mul_e2", res_a[2], 32'd9);
        chk("mul_e3", res_a[3], 32'd12);
        chk("mul_e4", res_a[4], 32'd15);
        chk("mul_e5", res_a[5], 32'hFFFFFFEE);
        chk("mul_wrap_e5", res_b[5], 32'hFFFFFFEE);
        chk("mul_rows", bus_a.actual_rows, 8'd2);
        chk("mul_cols", bus_a.actual_cols, 8'd3);
        chk("mul_matrix_id", bus_a.matrix_id, 3'd4);
        chk("mul_status", status_a, STATUS_SUCCESS);
        chk("mul_req_pulses", rq_a - rq0, 1);

        // ADD immediate at the positive limit: saturate vs wrap.
        sc0 = sc_hits;
        do_start(2'd1, 3'd2, 3'd4, 3'd1, 1'b1, 32'd5);
        collect(1, -1, 0);
        chk("add_sat", res_a[0], 32'h7FFFFFFF);
        chk("add_wrap", res_b[0], 32'h80000003);
        chk("add_no_scalar_read", sc_hits - sc0, 0);
        chk("add_status", status_a, STATUS_SUCCESS);

        // Q8 multiply and SUB going negative.
        do_start(2'd0, 3'd5, 3'd0, 3'd0, 1'b1, 32'h200);
        collect(1, -1, 0);
        chk("frac_mul", res_c[0], 32'h300);
        do_start(2'd2, 3'd6, 3'd0, 3'd0, 1'b1, 32'h300);
        collect(1, -1, 0);
        chk("sub_a", res_a[0], 32'hFFFFFE00);
        chk("sub_b", res_b[0], 32'hFFFFFE00);
        chk("sub_c", res_c[0], 32'hFFFFFE00);

        // Error paths.
        run_err("err_dim", 2'd0, 3'd0, 3'd4, 3'd2, 1'b0, STATUS_ERR_DIM);
        run_err("err_format", 2'd3, 3'd0, 3'd1, 3'd2, 1'b0, STATUS_ERR_FORMAT);
        run_err("err_empty", 2'd1, 3'd7, 3'd0, 3'd2, 1'b1, STATUS_ERR_EMPTY);
        rq0 = rq_a; dv0 = dv_a;
        do_start(2'd1, 3'd0, 3'd1, 3'd0, 1'b0, 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("err_id_fast", status_a, STATUS_ERR_ID);
        wait_idle("err_id_timeout");
        chk("err_id_no_req", rq_a - rq0, 0);
        chk("err_id_no_valid", dv_a - dv0, 0);

        // writer_ready stall on element 2 of 4.
        dv0 = dv_a;
        do_start(2'd1, 3'd3, 3'd0, 3'd5, 1'b1, 32'd1);
        collect(4, 1, 3);
        chk("stall_e0", res_a[0], 32'd11);
        chk("stall_e1", res_a[1], 32'd21);
        chk("stall_e2", res_a[2], 32'd31);
        chk("stall_e3", res_a[3], 32'd41);
        chk("stall_valid_cycles", dv_a - dv0, 7);
        chk("stall_status", status_a, STATUS_SUCCESS);

        // Asynchronous reset during element 3, then a fresh run.
        begin
            int got;
            got = 0;
            do_start(2'd0, 3'd3, 3'd1, 3'd2, 1'b0, 32'd0);
            for (int cyc = 0; cyc < 200 && got < 3; cyc++) begin
                @(negedge clk);
                if (bus_a.data_valid) got++;
            end
            chk("abort_reached_e3", got, 3);
            rst_n = 1'b0;
            #1;
            chk("abort_busy", busy_a, 1'b0);
            chk("abort_status", status_a, STATUS_IDLE);
            chk("abort_valid", bus_a.data_valid, 1'b0);
            chk("abort_data_in", bus_a.data_in, 32'd0);
            @(negedge clk);
            rst_n = 1'b1;
            repeat (5) @(negedge clk);
            chk("abort_no_completion", status_a, STATUS_IDLE);
        end
        do_start(2'd0, 3'd0, 3'd1, 3'd4, 1'b0, 32'd0);
        collect(6, -1, 0);
        chk("rerun_e1", res_a[1], 32'hFFFFFFFA);
        chk("rerun_e5", res_a[5], 32'hFFFFFFEE);
        chk("rerun_status", status_a, STATUS_SUCCESS);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
